// File: rtl/frame_buffer_scheduler_pkg.sv
// Shared types and helpers for the frame buffer scheduler: FSM states,
// buffer index type and the index-to-DRAM-base lookup.
package fb_sched_pkg;

   typedef enum logic [1:0] {
      START   = 2'd0,
      DRAW    = 2'd1,
      WAIT_VS = 2'd2
   } fsm_state_e;

   typedef logic [1:0] buf_idx_t;

   function automatic logic [31:0] idx_to_base(input buf_idx_t idx,
                                               input logic [31:0] b0,
                                               input logic [31:0] b1,
                                               input logic [31:0] b2);
      logic [31:0] base;
      case (idx)
         2'd0:    base = b0;
         2'd1:    base = b1;
         2'd2:    base = b2;
         default: base = b0;
      endcase
      return base;
   endfunction

endpackage

// File: rtl/frame_buffer_scheduler_if.sv
// Renderer/display handshake bundle; master is the scheduler, slave the
// renderer plus display timing and pixel feeder.
interface fb_sched_if
   import fb_sched_pkg::*;
#(
   parameter int CNT_W = 16
);
   logic             vsync;
   logic             draw_start;
   logic             draw_start_ack;
   logic [31:0]      draw_base;
   logic             draw_done;
   logic [31:0]      disp_base;
   buf_idx_t         disp_idx;
   buf_idx_t         draw_idx;
   buf_idx_t         ready_idx;
   logic             ready_valid;
   logic [CNT_W-1:0] frame_count;
   logic [CNT_W-1:0] drop_count;

   modport master (
      input  vsync, draw_start_ack, draw_done,
      output draw_start, draw_base, disp_base, disp_idx, draw_idx, ready_idx,
             ready_valid, frame_count, drop_count
   );

   modport slave (
      output vsync, draw_start_ack, draw_done,
      input  draw_start, draw_base, disp_base, disp_idx, draw_idx, ready_idx,
             ready_valid, frame_count, drop_count
   );
endinterface

// File: rtl/frame_buffer_scheduler_sat_counter.sv
// Registered event counter that either wraps or sticks at all-ones.
module sat_counter #(
   parameter int WIDTH    = 16,
   parameter bit SATURATE = 1'b0
) (
   input  logic             clock_i,
   input  logic             reset_ni,
   input  logic             inc_i,
   output logic [WIDTH-1:0] count_o
);
   logic [WIDTH-1:0] count_q;
   logic [WIDTH-1:0] count_d;

   // Next count: hold, increment, or hold at the ceiling when saturating
   always_comb begin
      count_d = count_q;
      if (inc_i) begin
         if (SATURATE && (&count_q)) begin
            count_d = count_q;
         end else begin
            count_d = count_q + {{(WIDTH-1){1'b0}}, 1'b1};
         end
      end else begin
         count_d = count_q;
      end
   end

   // Count register
   always_ff @(posedge clock_i or negedge reset_ni) begin
      if (!reset_ni) begin
         count_q <= {WIDTH{1'b0}};
      end else begin
         count_q <= count_d;
      end
   end

   assign count_o = count_q;
endmodule

// File: rtl/frame_buffer_scheduler.sv
// Rotates frame buffer roles between renderer and display, swapping the
// displayed buffer only on vsync so scan-out never tears.
module frame_buffer_scheduler
   import fb_sched_pkg::*;
#(
   parameter bit          TRIPLE = 1'b1,
   parameter logic [31:0] BASE0  = 32'h0000_0000,
   parameter logic [31:0] BASE1  = 32'h0010_0000,
   parameter logic [31:0] BASE2  = 32'h0020_0000,
   parameter int          CNT_W  = 16
) (
   input  logic      clock_i,
   input  logic      reset_ni,
   fb_sched_if.master bus
);
   fsm_state_e  state_q, state_d;
   buf_idx_t    disp_q, disp_d;
   buf_idx_t    draw_q, draw_d;
   buf_idx_t    ready_q, ready_d;
   buf_idx_t    swap_tmp;
   logic        ready_valid_q, ready_valid_d;
   logic        draw_start_q, draw_start_d;
   logic [31:0] draw_base_q, draw_base_d;
   logic [31:0] disp_base_q, disp_base_d;
   logic        frame_inc;
   logic        drop_inc;

   // Role update: vsync effects first, then draw_done acts on the updated roles
   always_comb begin
      state_d       = state_q;
      disp_d        = disp_q;
      draw_d        = draw_q;
      ready_d       = ready_q;
      ready_valid_d = ready_valid_q;
      draw_start_d  = draw_start_q;
      swap_tmp      = draw_q;
      frame_inc     = 1'b0;
      drop_inc      = 1'b0;

      if (TRIPLE) begin
         if (bus.vsync && ready_valid_q) begin
            disp_d        = ready_q;
            ready_d       = disp_q;
            ready_valid_d = 1'b0;
            frame_inc     = 1'b1;
         end else begin
            disp_d = disp_q;
         end
      end else begin
         if (bus.vsync && (state_q == WAIT_VS)) begin
            disp_d        = draw_q;
            draw_d        = disp_q;
            ready_valid_d = 1'b0;
            frame_inc     = 1'b1;
            draw_start_d  = 1'b1;
            state_d       = START;
         end else begin
            disp_d = disp_q;
         end
      end

      case (state_q)
         START: begin
            if (bus.draw_start_ack) begin
               draw_start_d = 1'b0;
               state_d      = DRAW;
            end else begin
               draw_start_d = 1'b1;
            end
         end
         DRAW: begin
            if (bus.draw_done) begin
               ready_valid_d = 1'b1;
               if (TRIPLE) begin
                  // A still-unshown ready frame is overwritten by the newer one
                  drop_inc     = ready_valid_d & ready_valid_q & ~frame_inc;
                  swap_tmp     = draw_d;
                  draw_d       = ready_d;
                  ready_d      = swap_tmp;
                  draw_start_d = 1'b1;
                  state_d      = START;
               end else begin
                  state_d = WAIT_VS;
               end
            end else begin
               state_d = DRAW;
            end
         end
         WAIT_VS: begin
            state_d = state_d;
         end
         default: begin
            state_d = START;
         end
      endcase

      draw_base_d = idx_to_base(draw_d, BASE0, BASE1, BASE2);
      disp_base_d = idx_to_base(disp_d, BASE0, BASE1, BASE2);
   end

   // Role, handshake and base address registers
   always_ff @(posedge clock_i or negedge reset_ni) begin
      if (!reset_ni) begin
         state_q       <= START;
         disp_q        <= 2'd0;
         draw_q        <= 2'd1;
         ready_q       <= 2'd2;
         ready_valid_q <= 1'b0;
         draw_start_q  <= 1'b1;
         draw_base_q   <= BASE1;
         disp_base_q   <= BASE0;
      end else begin
         state_q       <= state_d;
         disp_q        <= disp_d;
         draw_q        <= draw_d;
         ready_q       <= ready_d;
         ready_valid_q <= ready_valid_d;
         draw_start_q  <= draw_start_d;
         draw_base_q   <= draw_base_d;
         disp_base_q   <= disp_base_d;
      end
   end

   sat_counter #(.WIDTH(CNT_W), .SATURATE(1'b0)) u_frame_cnt (
      .clock_i  (clock_i),
      .reset_ni (reset_ni),
      .inc_i    (frame_inc),
      .count_o  (bus.frame_count)
   );

   sat_counter #(.WIDTH(CNT_W), .SATURATE(1'b1)) u_drop_cnt (
      .clock_i  (clock_i),
      .reset_ni (reset_ni),
      .inc_i    (drop_inc),
      .count_o  (bus.drop_count)
   );

   assign bus.draw_start  = draw_start_q;
   assign bus.draw_base   = draw_base_q;
   assign bus.disp_base   = disp_base_q;
   assign bus.disp_idx    = disp_q;
   assign bus.draw_idx    = draw_q;
   assign bus.ready_idx   = ready_q;
   assign bus.ready_valid = ready_valid_q;
endmodule

// File: tb/tb_frame_buffer_scheduler.sv
// Directed bench for a triple- and a double-buffered scheduler instance;
// expected states are queued by the stimulus and checked by a monitor.
module tb_frame_buffer_scheduler;
   import fb_sched_pkg::*;

   localparam logic [31:0] B0 = 32'h0000_0000;
   localparam logic [31:0] B1 = 32'h0010_0000;
   localparam logic [31:0] B2 = 32'h0020_0000;

   typedef struct packed {
      logic        ds;
      logic        rv;
      logic [1:0]  disp;
      logic [1:0]  draw;
      logic [1:0]  ready;
      logic [31:0] disp_base;
      logic [31:0] draw_base;
      logic [15:0] frame;
      logic [15:0] drop;
   } snap_t;

   typedef struct {
      int    cyc;
      int    dut;
      snap_t s;
   } sb_entry_t;

   logic clk;
   logic rst_n;
   int   cyc;
   int   total;
   int   bad;
   sb_entry_t sb[$];
   snap_t e0;
   snap_t e1;
   snap_t rst_snap;

   fb_sched_if #(.CNT_W(16)) bus0 ();
   fb_sched_if #(.CNT_W(16)) bus1 ();

   frame_buffer_scheduler #(.TRIPLE(1'b1), .BASE0(B0), .BASE1(B1), .BASE2(B2), .CNT_W(16)) dut_triple (
      .clock_i  (clk),
      .reset_ni (rst_n),
      .bus      (bus0)
   );

   frame_buffer_scheduler #(.TRIPLE(1'b0), .BASE0(B0), .BASE1(B1), .BASE2(B2), .CNT_W(16)) dut_double (
      .clock_i  (clk),
      .reset_ni (rst_n),
      .bus      (bus1)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial begin
      cyc = 0;
      forever begin
         @(posedge clk);
         cyc++;
         if (cyc > 5000) begin
            $display("FAIL watchdog cyc=%0d limit=5000", cyc);
            $fatal(1);
         end
      end
   end

   function automatic snap_t snap(input int d);
      snap_t s;
      if (d == 0) begin
         s = {bus0.draw_start, bus0.ready_valid, bus0.disp_idx, bus0.draw_idx, bus0.ready_idx,
              bus0.disp_base, bus0.draw_base, bus0.frame_count, bus0.drop_count};
      end else begin
         s = {bus1.draw_start, bus1.ready_valid, bus1.disp_idx, bus1.draw_idx, bus1.ready_idx,
              bus1.disp_base, bus1.draw_base, bus1.frame_count, bus1.drop_count};
      end
      return s;
   endfunction

   // Monitor: compares every queued expectation in the cycle it is due
   initial begin
      sb_entry_t en;
      snap_t act;
      total = 0;
      bad   = 0;
      forever begin
         @(negedge clk);
         while (sb.size() > 0 && sb[0].cyc <= cyc) begin
            en  = sb.pop_front();
            act = snap(en.dut);
            total++;
            if (en.cyc != cyc || act !== en.s) begin
               bad++;
               $display("FAIL dut%0d_cyc%0d got=%h want=%h", en.dut, en.cyc, act, en.s);
            end
         end
      end
   end

   task automatic push_both();
      sb.push_back('{cyc: cyc, dut: 0, s: e0});
      sb.push_back('{cyc: cyc, dut: 1, s: e1});
   endtask

   task automatic run(input int n);
      for (int i = 0; i < n; i++) begin
         @(posedge clk);
         #1;
         bus0.vsync = 1'b0; bus0.draw_done = 1'b0; bus0.draw_start_ack = 1'b0;
         bus1.vsync = 1'b0; bus1.draw_done = 1'b0; bus1.draw_start_ack = 1'b0;
         push_both();
      end
   endtask

   initial begin
      rst_snap = '{ds: 1'b1, rv: 1'b0, disp: 2'd0, draw: 2'd1, ready: 2'd2,
                   disp_base: B0, draw_base: B1, frame: 16'd0, drop: 16'd0};
      rst_n = 1'b0;
      bus0.vsync = 1'b0; bus0.draw_done = 1'b0; bus0.draw_start_ack = 1'b0;
      bus1.vsync = 1'b0; bus1.draw_done = 1'b0; bus1.draw_start_ack = 1'b0;
      e0 = rst_snap;
      e1 = rst_snap;
      repeat (2) @(posedge clk);
      #1 rst_n = 1'b1;
      push_both();
      run(2);

      // Triple: ack, then draw_done and vsync five cycles later
      bus0.draw_start_ack = 1'b1; e0.ds = 1'b0; run(1);
      bus0.draw_done = 1'b1;
      e0.ds = 1'b1; e0.rv = 1'b1; e0.draw = 2'd2; e0.ready = 2'd1; e0.draw_base = B2;
      run(1);
      run(4);
      bus0.vsync = 1'b1;
      e0.disp = 2'd1; e0.ready = 2'd0; e0.rv = 1'b0; e0.frame = 16'd1; e0.disp_base = B1;
      run(1);

      // Triple: two frames finish before vsync, the older one is dropped
      bus0.draw_start_ack = 1'b1; e0.ds = 1'b0; run(1);
      bus0.draw_done = 1'b1;
      e0.ds = 1'b1; e0.rv = 1'b1; e0.draw = 2'd0; e0.ready = 2'd2; e0.draw_base = B0;
      run(1);
      bus0.draw_start_ack = 1'b1; e0.ds = 1'b0; run(1);
      bus0.draw_done = 1'b1;
      e0.ds = 1'b1; e0.drop = 16'd1; e0.draw = 2'd2; e0.ready = 2'd0; e0.draw_base = B2;
      run(1);
      run(2);
      bus0.vsync = 1'b1;
      e0.disp = 2'd0; e0.ready = 2'd1; e0.rv = 1'b0; e0.frame = 16'd2; e0.disp_base = B0;
      run(1);

      // Triple: simultaneous vsync and draw_done with a frame already ready
      bus0.draw_start_ack = 1'b1; e0.ds = 1'b0; run(1);
      bus0.draw_done = 1'b1;
      e0.ds = 1'b1; e0.rv = 1'b1; e0.draw = 2'd1; e0.ready = 2'd2; e0.draw_base = B1;
      run(1);
      bus0.draw_start_ack = 1'b1; e0.ds = 1'b0; run(1);
      bus0.vsync = 1'b1; bus0.draw_done = 1'b1;
      e0.disp = 2'd2; e0.draw = 2'd0; e0.ready = 2'd1; e0.rv = 1'b1; e0.ds = 1'b1;
      e0.frame = 16'd3; e0.disp_base = B2; e0.draw_base = B0;
      run(1);

      // Triple: ignored events (done in START, ack in DRAW), vsync with nothing ready
      bus0.draw_done = 1'b1; run(1);
      bus0.draw_start_ack = 1'b1; e0.ds = 1'b0; run(1);
      bus0.draw_start_ack = 1'b1; run(1);
      bus0.vsync = 1'b1;
      e0.disp = 2'd1; e0.ready = 2'd2; e0.rv = 1'b0; e0.frame = 16'd4; e0.disp_base = B1;
      run(1);
      bus0.vsync = 1'b1; run(1);

      // Reset pulse mid-frame with nonzero counters
      @(posedge clk);
      #1 rst_n = 1'b0;
      #1;
      e0 = rst_snap;
      e1 = rst_snap;
      push_both();
      @(posedge clk);
      #1 rst_n = 1'b1;
      push_both();
      run(2);

      // Double: vsync in DRAW ignored, done, extra done in WAIT_VS ignored
      bus1.draw_start_ack = 1'b1; e1.ds = 1'b0; run(1);
      bus1.vsync = 1'b1; run(1);
      bus1.draw_done = 1'b1; e1.rv = 1'b1; run(1);
      bus1.draw_done = 1'b1; run(1);
      run(2);
      bus1.vsync = 1'b1;
      e1.disp = 2'd1; e1.draw = 2'd0; e1.rv = 1'b0; e1.ds = 1'b1; e1.frame = 16'd1;
      e1.disp_base = B1; e1.draw_base = B0;
      run(1);
      run(9);
      bus1.vsync = 1'b1; run(1);
      run(9);
      bus1.vsync = 1'b1; run(1);

      // Double: vsync with draw_done in DRAW takes the done, swap at next vsync
      bus1.draw_start_ack = 1'b1; e1.ds = 1'b0; run(1);
      bus1.vsync = 1'b1; bus1.draw_done = 1'b1; e1.rv = 1'b1; run(1);
      run(2);
      bus1.vsync = 1'b1;
      e1.disp = 2'd0; e1.draw = 2'd1; e1.rv = 1'b0; e1.ds = 1'b1; e1.frame = 16'd2;
      e1.disp_base = B0; e1.draw_base = B1;
      run(1);
      run(1);

      for (int i = 0; i < 20; i++) begin
         if (sb.size() == 0) break;
         @(negedge clk);
      end
      #1;
      if (sb.size() != 0) begin
         bad++;
         $display("FAIL drain pending=%0d want=0", sb.size());
      end
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule

// File: doc/frame_buffer_scheduler.md
# frame_buffer_scheduler

Sequences the renderer and the display across a pool of frame buffers in DRAM, as double or triple buffering. Tells the background renderer which buffer to draw into and when to start. Tells the display pixel feeder which buffer base to scan out. Swaps only on the display's vsync pulse, so scan-out never tears.

## Interface
- `TRIPLE`, 1: 1 = triple buffering (3 buffers); 0 = double buffering (buffers 0/1 only).
- `BASE0`, `BASE1`, `BASE2`, 32'h0000_0000 / 32'h0010_0000 / 32'h0020_0000: DRAM base address of each buffer.
- `CNT_W`, 16: width of the statistics counters.
- `clock` in 1: single clock for all logic.
- `reset` in 1: asynchronous, active-low; all state returns to reset values immediately.
- `vsync` in 1: one-cycle pulse from display timing, start of vertical blank.
- `draw_start` out 1: request to the renderer; held high until acknowledged.
- `draw_start_ack` in 1: renderer accepts the start.
- `draw_base` out 32: base address the renderer must draw into.
- `draw_done` in 1: one-cycle pulse, renderer finished the frame.
- `disp_base` out 32: base address the display feeder scans out.
- `disp_idx`, `draw_idx`, `ready_idx` out 2 each: current buffer roles.
- `ready_valid` out 1: a completed frame is waiting for display.
- `frame_count` out CNT_W: display swaps performed; wraps.
- `drop_count` out CNT_W: completed frames discarded unshown; saturates at all-ones.

## Operation
- Roles are registered indices `disp_idx`, `draw_idx`, `ready_idx`.
  - In triple mode they always form a permutation of {0,1,2}.
  - In double mode `ready_idx` is fixed at 2 and unused.
- Reset values: `disp_idx`=0, `draw_idx`=1, `ready_idx`=2, `ready_valid`=0, `draw_start`=1, FSM=START, counters=0, `disp_base`=BASE0, `draw_base`=BASE1.
- FSM states: START, DRAW, WAIT_VS. WAIT_VS is reachable only when TRIPLE=0.
- START: `draw_start`=1. On `draw_start_ack`, clear `draw_start` and go to DRAW.
- DRAW, TRIPLE=1, on `draw_done`:
  - Swap `draw_idx` with `ready_idx`.
  - If `ready_valid` was already 1, increment `drop_count`; the older unshown frame is recycled.
  - Set `ready_valid`=1 and go to START. The renderer never stalls.
- DRAW, TRIPLE=0, on `draw_done`: set `ready_valid`=1 and go to WAIT_VS.
- vsync, TRIPLE=1:
  - If `ready_valid`: swap `disp_idx` with `ready_idx`, clear `ready_valid`, increment `frame_count`.
  - Otherwise hold the display; the same frame repeats.
- vsync, TRIPLE=0, in WAIT_VS: swap `disp_idx` with `draw_idx`, clear `ready_valid`, increment `frame_count`, go to START. vsync in START or DRAW has no effect.
- `vsync` and `draw_done` in the same cycle: vsync is applied first, then `draw_done` on the updated indices.
  - Triple mode, `ready_valid`=1: display takes the old ready buffer; the new frame becomes ready; no drop.
  - Double mode, in DRAW: `draw_done` is taken; the swap waits for the next vsync.
- Ignored events, with no state change:
  - `draw_done` outside DRAW (protocol violation).
  - `draw_start_ack` outside START.
- `draw_base`/`disp_base` are the registered lookups of BASEn by `draw_idx`/`disp_idx`.
  - `draw_base` is stable whenever `draw_start`=1 or FSM=DRAW.

## Timing
- All outputs are registered; no combinational input-to-output paths.
- `draw_start` falls on the edge after `draw_start_ack` is sampled high.
- Triple mode: `draw_start` re-asserts on the edge after `draw_done`, with the new `draw_base` valid in that same cycle.
- `disp_base` updates on the edge that samples `vsync`. The feeder sees the new base in the cycle after the pulse.
- A `draw_done` pulse 1 cycle before `vsync` is shown at that `vsync`.
- Reset asserted mid-frame: outputs return to reset values asynchronously. `draw_start` is high in the first cycle after release.

## Structure
- Shared package `fb_sched_pkg`:
  - FSM state enum `{START, DRAW, WAIT_VS}`.
  - 2-bit buffer index type.
  - Function mapping index to base address from the BASE parameters.
- Counters are a natural sub-module, `sat_counter` (width param, wrap/saturate select, increment enable). Instantiate it twice.

## Test plan
- Reset release, TRIPLE=1 → `draw_start`=1, `draw_base`=BASE1, `disp_base`=BASE0. Ack at cycle 3 → `draw_start`=0 at cycle 4.
- TRIPLE=1, `draw_done` at t, `vsync` at t+5 → at t+1 ready=1, draw=2, `draw_start`=1. After vsync: disp=1, ready=0, `frame_count`=1.
- TRIPLE=1, two `draw_done` before any `vsync` → `drop_count`=1. Next vsync shows the second frame's buffer.
- TRIPLE=0, `draw_done` then 3 vsyncs spaced 10 cycles → swap only at the first vsync, disp=1, draw=0, `draw_start`=1. Later vsyncs do not increment `frame_count`.
- Simultaneous `vsync`+`draw_done` with ready_valid=1 (disp=0, ready=1, draw=2) → disp=1, ready=2, draw=0, ready_valid=1, `drop_count` unchanged.
- `reset` low for 1 cycle while in DRAW with counters nonzero → all reset values immediately, including counters=0 and `draw_start`=1 after release.
